// File: rtl/tictactoe_turn_ctrl_if.sv
// Move-request / board-status bundle between the switch+key front end and the turn controller.
// master = player input side, slave = tictactoe_turn_ctrl.
interface tictactoe_turn_ctrl_if;
    logic        confirm;
    logic [3:0]  address;
    logic [17:0] board;
    logic [1:0]  cur_player;
    logic [1:0]  winner;
    logic        game_over;
    logic        busy;
    logic        illegal_move;
    logic        timeout;

    modport master (
        output confirm, address,
        input  board, cur_player, winner, game_over, busy, illegal_move, timeout
    );

    modport slave (
        input  confirm, address,
        output board, cur_player, winner, game_over, busy, illegal_move, timeout
    );
endinterface

// File: rtl/tictactoe_turn_ctrl.sv
// Turn sequencer and move arbiter for the shared tic-tac-toe board register.
// Define MOVE_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYCLES idle cycles.
module tictactoe_turn_ctrl
`ifdef MOVE_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
)
`endif
(
    input logic                  clk,
    input logic                  reset,
    tictactoe_turn_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        VALIDATE,
        WRITE,
        CHECK,
        SWITCH,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        confirm_q;
    logic [3:0]  addr_q;
    logic [3:0]  move_count;
    logic [2:0]  line_idx;
    logic [17:0] board_q;
    logic [1:0]  cur_player_q;
    logic [1:0]  winner_q;
    logic        illegal_q;

    logic        confirm_edge;
    logic        target_free;
    logic        line_match;
    logic [11:0] line_sel;

    logic        latch_addr;
    logic        reject;
    logic        do_write;
    logic        advance_line;
    logic        set_win;
    logic        set_draw;
    logic        toggle_player;
    logic        fire_timeout;

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        cell_at = 2'b00;
        for (int i = 0; i < 9; i++) begin
            if (idx == i[3:0]) begin
                cell_at = b[2*i +: 2];
            end
        end
    endfunction

    // Winning lines packed as three 4-bit cell indices, scanned in this order.
    function automatic logic [11:0] line_cells(input logic [2:0] k);
        line_cells = {4'd0, 4'd1, 4'd2};
        case (k)
            3'd0: line_cells = {4'd0, 4'd1, 4'd2};
            3'd1: line_cells = {4'd3, 4'd4, 4'd5};
            3'd2: line_cells = {4'd6, 4'd7, 4'd8};
            3'd3: line_cells = {4'd0, 4'd3, 4'd6};
            3'd4: line_cells = {4'd1, 4'd4, 4'd7};
            3'd5: line_cells = {4'd2, 4'd5, 4'd8};
            3'd6: line_cells = {4'd0, 4'd4, 4'd8};
            3'd7: line_cells = {4'd2, 4'd4, 4'd6};
            default: line_cells = {4'd0, 4'd1, 4'd2};
        endcase
    endfunction

    assign confirm_edge = bus.confirm & ~confirm_q;
    assign target_free  = (addr_q <= 4'd8) && (cell_at(board_q, addr_q) == 2'b00);
    assign line_sel     = line_cells(line_idx);
    // Only the mover can have completed a line, so only its code is compared.
    assign line_match   = (cell_at(board_q, line_sel[11:8]) == cur_player_q) &&
                          (cell_at(board_q, line_sel[7:4])  == cur_player_q) &&
                          (cell_at(board_q, line_sel[3:0])  == cur_player_q);

`ifdef MOVE_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_count;
    logic            timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        latch_addr    = 1'b0;
        reject        = 1'b0;
        do_write      = 1'b0;
        advance_line  = 1'b0;
        set_win       = 1'b0;
        set_draw      = 1'b0;
        toggle_player = 1'b0;
        fire_timeout  = 1'b0;

        case (state)
            IDLE: begin
                if (confirm_edge) begin
                    latch_addr = 1'b1;
                    state_next = VALIDATE;
`ifdef MOVE_TIMEOUT_EN
                end else if (idle_count == TO_LAST) begin
                    fire_timeout = 1'b1;
`endif
                end
            end
            VALIDATE: begin
                if (target_free) begin
                    state_next = WRITE;
                end else begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                do_write   = 1'b1;
                state_next = CHECK;
            end
            CHECK: begin
                if (line_match) begin
                    set_win    = 1'b1;
                    state_next = DONE;
                end else if (line_idx == 3'd7) begin
                    if (move_count == 4'd9) begin
                        set_draw   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = SWITCH;
                    end
                end else begin
                    advance_line = 1'b1;
                end
            end
            SWITCH: begin
                toggle_player = 1'b1;
                state_next    = IDLE;
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            confirm_q    <= 1'b0;
            addr_q       <= 4'd0;
            move_count   <= 4'd0;
            line_idx     <= 3'd0;
            board_q      <= 18'd0;
            cur_player_q <= 2'b01;
            winner_q     <= 2'b00;
            illegal_q    <= 1'b0;
        end else begin
            confirm_q <= bus.confirm;
            illegal_q <= reject;
            if (latch_addr) begin
                addr_q <= bus.address;
            end
            if (do_write) begin
                for (int i = 0; i < 9; i++) begin
                    if (addr_q == i[3:0]) begin
                        board_q[2*i +: 2] <= cur_player_q;
                    end
                end
                move_count <= move_count + 4'd1;
                line_idx   <= 3'd0;
            end
            if (advance_line) begin
                line_idx <= line_idx + 3'd1;
            end
            if (set_win) begin
                winner_q <= cur_player_q;
            end
            if (set_draw) begin
                winner_q <= 2'b11;
            end
            // 01 and 10 are bitwise complements, so inversion swaps players.
            if (toggle_player || fire_timeout) begin
                cur_player_q <= ~cur_player_q;
            end
        end
    end

`ifdef MOVE_TIMEOUT_EN
    // Idle counter only advances while waiting for a move in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_count <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= fire_timeout;
            if (state_next != IDLE || fire_timeout) begin
                idle_count <= '0;
            end else begin
                idle_count <= idle_count + 1'b1;
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.board        = board_q;
    assign bus.cur_player   = cur_player_q;
    assign bus.winner       = winner_q;
    assign bus.illegal_move = illegal_q;
    assign bus.game_over    = (state == DONE);
    assign bus.busy         = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_tictactoe_turn_ctrl.sv
// Directed bench for tictactoe_turn_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_tictactoe_turn_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   busy_cycles;
    int   timeout_pulses;

    tictactoe_turn_ctrl_if bus();

    tictactoe_turn_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [17:0] observed, input logic [17:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raises confirm for one cycle (cycle N); returns at the falling edge of cycle N+1.
    task automatic applyStimulus(input logic [3:0] addr);
        @(negedge clk);
        bus.confirm = 1'b1;
        bus.address = addr;
        @(negedge clk);
        bus.confirm = 1'b0;
    endtask

    // Complete non-terminal move; returns in cycle N+12 with the FSM back in IDLE.
    task automatic fullMove(input logic [3:0] addr);
        applyStimulus(addr);
        skip(11);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.confirm = 1'b0;
        bus.address = 4'd0;
        skip(2);
        checkOutput("rst_board",   bus.board,             18'h0);
        checkOutput("rst_player",  18'(bus.cur_player),   18'd1);
        checkOutput("rst_winner",  18'(bus.winner),       18'd0);
        checkOutput("rst_over",    18'(bus.game_over),    18'd0);
        checkOutput("rst_busy",    18'(bus.busy),         18'd0);
        checkOutput("rst_illegal", 18'(bus.illegal_move), 18'd0);
        checkOutput("rst_timeout", 18'(bus.timeout),      18'd0);
        reset = 1'b0;

        $display("[TB] first move on centre cell");
        applyStimulus(4'd4);
        checkOutput("m4_busy_n1",   18'(bus.busy),       18'd1);
        skip(1);
        checkOutput("m4_board_n2",  bus.board,           18'h0);
        skip(1);
        checkOutput("m4_board_n3",  bus.board,           18'h00100);
        skip(8);
        checkOutput("m4_player_n11", 18'(bus.cur_player), 18'd1);
        checkOutput("m4_busy_n11",  18'(bus.busy),       18'd1);
        skip(1);
        checkOutput("m4_player_n12", 18'(bus.cur_player), 18'd2);
        checkOutput("m4_winner_n12", 18'(bus.winner),     18'd0);
        checkOutput("m4_busy_n12",  18'(bus.busy),       18'd0);

        $display("[TB] illegal moves");
        applyStimulus(4'd4);
        checkOutput("occ_illegal_n1", 18'(bus.illegal_move), 18'd0);
        skip(1);
        checkOutput("occ_illegal_n2", 18'(bus.illegal_move), 18'd1);
        checkOutput("occ_busy_n2",    18'(bus.busy),         18'd0);
        skip(1);
        checkOutput("occ_illegal_n3", 18'(bus.illegal_move), 18'd0);
        checkOutput("occ_board",      bus.board,             18'h00100);
        checkOutput("occ_player",     18'(bus.cur_player),   18'd2);
        applyStimulus(4'd9);
        skip(1);
        checkOutput("a9_illegal_n2",  18'(bus.illegal_move), 18'd1);
        checkOutput("a9_board",       bus.board,             18'h00100);
        checkOutput("a9_player",      18'(bus.cur_player),   18'd2);

        $display("[TB] reset during line scan");
        applyStimulus(4'd0);
        skip(3);
        checkOutput("midchk_board", bus.board,       18'h00102);
        checkOutput("midchk_busy",  18'(bus.busy),   18'd1);
        reset = 1'b1;
        skip(1);
        checkOutput("midrst_board",  bus.board,           18'h0);
        checkOutput("midrst_player", 18'(bus.cur_player), 18'd1);
        checkOutput("midrst_busy",   18'(bus.busy),       18'd0);
        checkOutput("midrst_over",   18'(bus.game_over),  18'd0);
        reset = 1'b0;

        $display("[TB] confirm held high");
        @(negedge clk);
        bus.confirm = 1'b1;
        bus.address = 4'd5;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
        end
        bus.confirm = 1'b0;
        checkOutput("hold_busy_cycles", 18'(busy_cycles),    18'd11);
        checkOutput("hold_board",       bus.board,           18'h00400);
        checkOutput("hold_player",      18'(bus.cur_player), 18'd2);

        $display("[TB] row 0 win for player one");
        doReset();
        fullMove(4'd0);
        fullMove(4'd3);
        fullMove(4'd1);
        fullMove(4'd4);
        checkOutput("row_player_before", 18'(bus.cur_player), 18'd1);
        applyStimulus(4'd2);
        skip(2);
        checkOutput("row_over_n3",   18'(bus.game_over), 18'd0);
        checkOutput("row_board_n3",  bus.board,          18'h00295);
        skip(1);
        checkOutput("row_over_n4",   18'(bus.game_over), 18'd1);
        checkOutput("row_winner_n4", 18'(bus.winner),    18'd1);
        checkOutput("row_busy_n4",   18'(bus.busy),      18'd0);
        applyStimulus(4'd7);
        skip(12);
        checkOutput("done_board",   bus.board,             18'h00295);
        checkOutput("done_winner",  18'(bus.winner),       18'd1);
        checkOutput("done_over",    18'(bus.game_over),    18'd1);
        checkOutput("done_illegal", 18'(bus.illegal_move), 18'd0);

        $display("[TB] anti-diagonal win for player two");
        doReset();
        fullMove(4'd0);
        fullMove(4'd2);
        fullMove(4'd1);
        fullMove(4'd4);
        fullMove(4'd8);
        applyStimulus(4'd6);
        skip(9);
        checkOutput("diag_over_n10",   18'(bus.game_over), 18'd0);
        skip(1);
        checkOutput("diag_over_n11",   18'(bus.game_over), 18'd1);
        checkOutput("diag_winner_n11", 18'(bus.winner),    18'd2);
        checkOutput("diag_board",      bus.board,          18'h12225);

        $display("[TB] full board draw");
        doReset();
        fullMove(4'd0);
        fullMove(4'd1);
        fullMove(4'd2);
        fullMove(4'd4);
        fullMove(4'd3);
        fullMove(4'd5);
        fullMove(4'd7);
        fullMove(4'd6);
        checkOutput("draw_winner_pre", 18'(bus.winner), 18'd0);
        applyStimulus(4'd8);
        skip(9);
        checkOutput("draw_over_n10",   18'(bus.game_over), 18'd0);
        checkOutput("draw_busy_n10",   18'(bus.busy),      18'd1);
        skip(1);
        checkOutput("draw_winner_n11", 18'(bus.winner),    18'd3);
        checkOutput("draw_over_n11",   18'(bus.game_over), 18'd1);
        checkOutput("draw_board",      bus.board,          18'h16A59);

        $display("[TB] idle behaviour");
        doReset();
        timeout_pulses = 0;
`ifdef MOVE_TIMEOUT_EN
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (bus.timeout) timeout_pulses++;
        end
        checkOutput("idle_timeout_pulses", 18'(timeout_pulses),  18'd1);
        checkOutput("idle_player",         18'(bus.cur_player),  18'd2);
        checkOutput("idle_board",          bus.board,            18'h0);
`else
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.timeout) timeout_pulses++;
        end
        checkOutput("idle_timeout_pulses", 18'(timeout_pulses),  18'd0);
        checkOutput("idle_player",         18'(bus.cur_player),  18'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tictactoe_turn_ctrl.md
# tictactoe_turn_ctrl

Turn sequencer and move arbiter for the two-player tic-tac-toe board. Shares the single board register between player one (O) and player two (X). Accepts one confirmed move at a time, rejects illegal moves, writes the cell, then scans the eight winning lines sequentially. Sits between the board-select switches/confirm key and the HEX/LEDR display logic, replacing ad-hoc load FSMs.

## Interface
- TIMEOUT_CYCLES, 1000, idle cycles before the current player forfeits the turn (used only with MOVE_TIMEOUT_EN)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- confirm  in  1  move confirm level, active-high, already synchronized; acted on at rising edge only
- address  in  4  target cell, 0..8 row-major (0 top-left, 8 bottom-right)
- board  out  18  cell i at board[2i+1:2i]; 2'b00 empty, 2'b01 O (player one), 2'b10 X (player two)
- cur_player  out  2  player to move: 2'b01 or 2'b10
- winner  out  2  2'b00 undecided, 2'b01 player one, 2'b10 player two, 2'b11 draw
- game_over  out  1  high in DONE
- busy  out  1  high in every state except IDLE and DONE
- illegal_move  out  1  one-cycle pulse on rejected move
- timeout  out  1  one-cycle pulse on forfeited turn (constant 0 without MOVE_TIMEOUT_EN)

## Operation
- Reset values: board 0, cur_player 2'b01, winner 2'b00, game_over 0, busy 0, illegal_move 0, timeout 0, move_count 0, line index 0, confirm_q 0, state IDLE.
- Edge detect: confirm_q registers confirm every cycle in all states; an edge is confirm & ~confirm_q.
- States:
  - IDLE: an edge latches address into addr_q and moves to VALIDATE. Edges in any other state are discarded.
  - VALIDATE: if addr_q > 8 or the target cell is not 2'b00, pulse illegal_move and return to IDLE (player unchanged). Otherwise go to WRITE.
  - WRITE: write cur_player code into the cell, increment move_count (4-bit, 0..9), clear line index, go to CHECK.
  - CHECK: one line per cycle, index 0..7, order: rows (0,1,2), (3,4,5), (6,7,8); columns (0,3,6), (1,4,7), (2,5,8); diagonals (0,4,8), (2,4,6). A line matches when all three cells equal cur_player. On a match, winner <= cur_player and go to DONE immediately. After index 7 with no match: if move_count == 9, winner <= 2'b11 and go to DONE; otherwise go to SWITCH.
  - SWITCH: toggle cur_player (01<->10), go to IDLE.
  - DONE: terminal state. Board and winner hold. Only reset exits.
- Only the mover's code is checked, since only the mover can complete a line on that move.

## Timing
- Edge sampled in IDLE at cycle N: VALIDATE at N+1; board updated and visible at N+3; CHECK occupies N+3..N+10 at most.
- No win: SWITCH at N+11, IDLE with new cur_player at N+12. Next move edge is accepted from N+12.
- Win on line k: game_over is high from cycle N+4+k.
- Illegal move: illegal_move is high during cycle N+2; back in IDLE at N+2.
- Confirm held high throughout: one move only. A new rising edge is required.
- Edge arriving in the same cycle the FSM returns to IDLE is honoured only if it is sampled while the state register already equals IDLE.
- Reset asserted in any state, including mid-CHECK: all outputs return to reset values on the next clock edge, and the partial move is lost.

## Configuration
- MOVE_TIMEOUT_EN defined: 
  - A counter runs only in IDLE and clears on leaving IDLE or on reset.
  - When it reaches TIMEOUT_CYCLES-1, pulse timeout for one cycle, toggle cur_player, clear the counter, and stay in IDLE. The board is unchanged.
  - A confirm edge in the same cycle takes priority; no timeout fires.
- Undefined: no counter; timeout is tied 0; players may idle indefinitely.

## Test plan
- Reset, then edge with address 4: after 3 cycles board[9:8]=01. At N+12, cur_player=10, winner=00, busy=0.
- Player one plays 0, 1, 2; player two plays 3, 4 between those moves: winner=01 and game_over=1 at N+4 of the move to 2 (row 0, k=0). Further edges cause no change.
- Edge with address 4 when cell 4 is occupied, and an edge with address 9: each gives an illegal_move pulse at N+2. Board and cur_player are unchanged.
- Full-board sequence 0,1,2,4,3,5,7,6,8 with no line: after the ninth move, winner=11 and game_over=1 at N+11.
- Reset pulsed during CHECK: board=0, cur_player=01, state IDLE the next cycle. Confirm held high over 20 cycles: exactly one write.
- MOVE_TIMEOUT_EN with TIMEOUT_CYCLES=8: idle 8 cycles, then a timeout pulse and cur_player toggles. Without the macro, timeout stays 0 for 1000 cycles.
